// File: rtl/gshare_branch_predictor_if.sv
// Prediction, training and statistics signals between the ID-stage pipeline and the
// gshare direction predictor.
interface gshare_branch_predictor_if #(
   parameter int unsigned INDEX_WIDTH   = 6,
   parameter int unsigned HISTORY_WIDTH = 6
);
   logic                     pred_valid;
   logic [INDEX_WIDTH-1:0]   pred_pc_slice;
   logic                     pred_taken;
   logic [HISTORY_WIDTH-1:0] pred_ghr;
   logic                     upd_valid;
   logic [INDEX_WIDTH-1:0]   upd_pc_slice;
   logic [HISTORY_WIDTH-1:0] upd_ghr;
   logic                     upd_taken;
   logic                     upd_mispredict;
   logic [31:0]              stat_branches;
   logic [31:0]              stat_mispredicts;

   modport master (
      output pred_valid, pred_pc_slice, upd_valid, upd_pc_slice, upd_ghr, upd_taken,
             upd_mispredict,
      input  pred_taken, pred_ghr, stat_branches, stat_mispredicts
   );

   modport slave (
      input  pred_valid, pred_pc_slice, upd_valid, upd_pc_slice, upd_ghr, upd_taken,
             upd_mispredict,
      output pred_taken, pred_ghr, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor: saturating-counter table, speculative global history
// with mispredict repair, and saturating branch/mispredict statistics.
module gshare_branch_predictor #(
   parameter int unsigned INDEX_WIDTH   = 6,
   parameter int unsigned HISTORY_WIDTH = 6,
   parameter int unsigned COUNTER_WIDTH = 2,
   parameter int unsigned GSHARE_EN     = 1
) (
   input logic                     clk,
   input logic                     rst,
   gshare_branch_predictor_if.slave bp
);

   localparam int ENTRIES = 2 ** INDEX_WIDTH;
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};

   logic [COUNTER_WIDTH-1:0] table_q [ENTRIES];
   logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
   logic [31:0]              stat_branches_q, stat_branches_d;
   logic [31:0]              stat_mispredicts_q, stat_mispredicts_d;

   logic [INDEX_WIDTH-1:0]   pred_idx, upd_idx;
   logic [COUNTER_WIDTH-1:0] upd_cnt, upd_cnt_next;
   logic                     pred_taken_w;
   logic                     repair;

   // History sits in the LSBs of the index; bimodal mode ignores it but still tracks it.
   function automatic logic [INDEX_WIDTH-1:0] table_index(
      input logic [INDEX_WIDTH-1:0]   slice,
      input logic [HISTORY_WIDTH-1:0] ghr
   );
      logic [INDEX_WIDTH-1:0] hist;
      hist = '0;
      hist[HISTORY_WIDTH-1:0] = ghr;
      if (GSHARE_EN != 0) return slice ^ hist;
      return slice;
   endfunction

   // Concatenate then truncate so a 1-bit history needs no special case.
   function automatic logic [HISTORY_WIDTH-1:0] shift_in(
      input logic [HISTORY_WIDTH-1:0] ghr,
      input logic                     taken
   );
      logic [HISTORY_WIDTH:0] wide;
      wide = {ghr, taken};
      return wide[HISTORY_WIDTH-1:0];
   endfunction

   assign pred_idx     = table_index(bp.pred_pc_slice, ghr_q);
   assign upd_idx      = table_index(bp.upd_pc_slice, bp.upd_ghr);
   assign pred_taken_w = table_q[pred_idx][COUNTER_WIDTH-1];
   assign upd_cnt      = table_q[upd_idx];
   assign repair       = bp.upd_valid && bp.upd_mispredict;

   always_comb begin
      upd_cnt_next = upd_cnt;
      if (bp.upd_taken) begin
         if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + CNT_ONE;
      end else begin
         if (upd_cnt != CNT_ZERO) upd_cnt_next = upd_cnt - CNT_ONE;
      end
   end

   // Repair wins over a same-cycle speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (repair) begin
         ghr_d = shift_in(bp.upd_ghr, bp.upd_taken);
      end else if (bp.pred_valid) begin
         ghr_d = shift_in(ghr_q, pred_taken_w);
      end
   end

   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (bp.upd_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
         stat_branches_d = stat_branches_q + 32'd1;
      end
      if (repair && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
         stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
      end else if (bp.upd_valid) begin
         table_q[upd_idx] <= upd_cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q              <= '0;
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         ghr_q              <= ghr_d;
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign bp.pred_taken       = pred_taken_w;
   assign bp.pred_ghr         = ghr_q;
   assign bp.stat_branches    = stat_branches_q;
   assign bp.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: a gshare and a bimodal instance driven in lockstep and
// compared against an array-based reference model.
module tb_gshare_branch_predictor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gshare_branch_predictor_if #(.INDEX_WIDTH(6), .HISTORY_WIDTH(6)) bp_g ();
   gshare_branch_predictor_if #(.INDEX_WIDTH(6), .HISTORY_WIDTH(6)) bp_b ();

   gshare_branch_predictor #(
      .INDEX_WIDTH(6), .HISTORY_WIDTH(6), .COUNTER_WIDTH(2), .GSHARE_EN(1)
   ) dut_g (.clk(clk), .rst(rst), .bp(bp_g));

   gshare_branch_predictor #(
      .INDEX_WIDTH(6), .HISTORY_WIDTH(6), .COUNTER_WIDTH(2), .GSHARE_EN(0)
   ) dut_b (.clk(clk), .rst(rst), .bp(bp_b));

   // Index 0 = gshare instance, 1 = bimodal instance.
   logic        got_taken [2];
   logic [5:0]  got_ghr   [2];
   logic [31:0] got_br    [2];
   logic [31:0] got_mp    [2];
   assign got_taken[0] = bp_g.pred_taken;
   assign got_taken[1] = bp_b.pred_taken;
   assign got_ghr[0]   = bp_g.pred_ghr;
   assign got_ghr[1]   = bp_b.pred_ghr;
   assign got_br[0]    = bp_g.stat_branches;
   assign got_br[1]    = bp_b.stat_branches;
   assign got_mp[0]    = bp_g.stat_mispredicts;
   assign got_mp[1]    = bp_b.stat_mispredicts;

   int passed = 0;
   int total  = 0;

   // Reference model: plain integer counters 0..3, history as an integer mod 64.
   int    cnt [2][64];
   int    ghr [2];
   longint m_br;
   longint m_mp;

   function automatic int midx(int m, int slice, int g);
      return (m == 0) ? ((slice ^ g) % 64) : slice;
   endfunction

   function automatic bit mpred(int m, int slice);
      return cnt[m][midx(m, slice, ghr[m])] >= 2;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 64; i++) cnt[m][i] = 1;
         ghr[m] = 0;
      end
      m_br = 0;
      m_mp = 0;
   endtask

   task automatic model_step();
      int pv, ppc, uv, upc, ug, ut, um;
      pv = int'(bp_g.pred_valid);  ppc = int'(bp_g.pred_pc_slice);
      uv = int'(bp_g.upd_valid);   upc = int'(bp_g.upd_pc_slice);
      ug = int'(bp_g.upd_ghr);     ut  = int'(bp_g.upd_taken);
      um = int'(bp_g.upd_mispredict);
      for (int m = 0; m < 2; m++) begin
         bit pt;
         int i;
         pt = mpred(m, ppc);
         if (uv != 0) begin
            i = midx(m, upc, ug);
            if (ut != 0) cnt[m][i] = (cnt[m][i] == 3) ? 3 : cnt[m][i] + 1;
            else         cnt[m][i] = (cnt[m][i] == 0) ? 0 : cnt[m][i] - 1;
         end
         if (uv != 0 && um != 0) ghr[m] = (ug * 2 + ut) % 64;
         else if (pv != 0)       ghr[m] = (ghr[m] * 2 + int'(pt)) % 64;
      end
      if (uv != 0) m_br = (m_br >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_br + 1;
      if (uv != 0 && um != 0) m_mp = (m_mp >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mp + 1;
   endtask

   task automatic drive(input bit pv, input int ppc, input bit uv, input int upc,
                        input int ug, input bit ut, input bit um);
      bp_g.pred_valid = pv;  bp_g.pred_pc_slice = 6'(ppc);
      bp_g.upd_valid  = uv;  bp_g.upd_pc_slice  = 6'(upc);
      bp_g.upd_ghr    = 6'(ug); bp_g.upd_taken  = ut; bp_g.upd_mispredict = um;
      bp_b.pred_valid = pv;  bp_b.pred_pc_slice = 6'(ppc);
      bp_b.upd_valid  = uv;  bp_b.upd_pc_slice  = 6'(upc);
      bp_b.upd_ghr    = 6'(ug); bp_b.upd_taken  = ut; bp_b.upd_mispredict = um;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      drive(0, 5, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (got_taken[m] !== 1'b0) $display("FAIL reset_taken[%0d]: got %0d want 0", m, got_taken[m]);
         else passed++;
         total++;
         if (got_ghr[m] !== 6'd0) $display("FAIL reset_ghr[%0d]: got %0d want 0", m, got_ghr[m]);
         else passed++;
         total++;
         if (got_br[m] !== 32'd0 || got_mp[m] !== 32'd0)
            $display("FAIL reset_stats[%0d]: got %0d/%0d want 0/0", m, got_br[m], got_mp[m]);
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 64; s++) begin
         drive(0, s, 0, 0, 0, 0, 0);
         #1;
         total++;
         if (got_taken[0] !== 1'b0 || got_taken[1] !== 1'b0)
            $display("FAIL reset_sweep pc=%0d: got %0d/%0d want 0/0", s, got_taken[0], got_taken[1]);
         else passed++;
      end
   endtask

   task automatic test_saturation();
      bit want [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      for (int k = 0; k < 8; k++) begin
         drive(0, 5, 1, 5, 0, (k < 5), 0);
         tick();
         drive(0, 5, 0, 0, 0, 0, 0);
         #1;
         total++;
         if (got_taken[0] !== want[k] || got_taken[0] !== mpred(0, 5))
            $display("FAIL saturation step %0d: got %0d want %0d", k, got_taken[0], want[k]);
         else passed++;
      end
   endtask

   task automatic test_aliasing();
      int seq [3] = '{0, 0, 2};
      pulse_reset();
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 1, 0, 0, 1, 0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1, seq[k], 0, 0, 0, 0, 0);
         tick();
      end
      drive(0, 5, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (got_ghr[0] !== 6'b000101) $display("FAIL alias_ghr: got %0d want 5", got_ghr[0]);
      else passed++;
      total++;
      if (got_taken[0] !== 1'b1) $display("FAIL alias_gshare: got %0d want 1", got_taken[0]);
      else passed++;
      total++;
      if (got_taken[1] !== 1'b0 || got_ghr[1] !== 6'(ghr[1]))
         $display("FAIL alias_bimodal: got %0d/%0d want 0/%0d", got_taken[1], got_ghr[1], ghr[1]);
      else passed++;
   endtask

   task automatic test_repair();
      int trained [3] = '{0, 1, 3};
      pulse_reset();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, trained[k], 0, 1, 0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 0, 0, 0, 0);
         tick();
      end
      #1;
      total++;
      if (got_ghr[0] !== 6'b000111) $display("FAIL repair_spec_ghr: got %0d want 7", got_ghr[0]);
      else passed++;
      drive(1, 0, 1, 9, 1, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (got_ghr[m] !== 6'b000010) $display("FAIL repair_ghr[%0d]: got %0d want 2", m, got_ghr[m]);
         else passed++;
      end
      total++;
      if (got_br[0] !== 32'(m_br) || got_mp[0] !== 32'd1)
         $display("FAIL repair_stats: got %0d/%0d want %0d/1", got_br[0], got_mp[0], m_br);
      else passed++;
   endtask

   task automatic test_stats();
      pulse_reset();
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1),
               (k == 2 || k == 5 || k == 9));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (got_br[m] !== 32'd10 || got_mp[m] !== 32'd3)
            $display("FAIL stats_count[%0d]: got %0d/%0d want 10/3", m, got_br[m], got_mp[m]);
         else passed++;
      end
      force dut_g.stat_branches_q = 32'hFFFF_FFFE;
      force dut_g.stat_mispredicts_q = 32'hFFFF_FFFE;
      force dut_b.stat_branches_q = 32'hFFFF_FFFE;
      force dut_b.stat_mispredicts_q = 32'hFFFF_FFFE;
      #1;
      release dut_g.stat_branches_q;
      release dut_g.stat_mispredicts_q;
      release dut_b.stat_branches_q;
      release dut_b.stat_mispredicts_q;
      m_br = 64'hFFFF_FFFE;
      m_mp = 64'hFFFF_FFFE;
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, k, 0, 1, 1);
         tick();
         #1;
         total++;
         if (got_br[0] !== 32'hFFFF_FFFF || got_mp[0] !== 32'hFFFF_FFFF)
            $display("FAIL stats_saturate step %0d: got %h/%h want ffffffff/ffffffff",
                     k, got_br[0], got_mp[0]);
         else passed++;
      end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int k = 0; k < 400; k++) begin
         bit uv;
         uv = ($urandom_range(0, 1) == 1);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 63), uv, $urandom_range(0, 63),
               (uv && $urandom_range(0, 1) == 1) ? ghr[0] : $urandom_range(0, 63),
               $urandom_range(0, 1), $urandom_range(0, 3) == 0);
         #1;
         for (int m = 0; m < 2; m++) begin
            total++;
            if (got_taken[m] !== mpred(m, int'(bp_g.pred_pc_slice)) || got_ghr[m] !== 6'(ghr[m])
                || got_br[m] !== 32'(m_br) || got_mp[m] !== 32'(m_mp))
               $display("FAIL random[%0d] cyc %0d: got t=%0d g=%0d b=%0d m=%0d want t=%0d g=%0d b=%0d m=%0d",
                        m, k, got_taken[m], got_ghr[m], got_br[m], got_mp[m],
                        mpred(m, int'(bp_g.pred_pc_slice)), ghr[m], m_br, m_mp);
            else passed++;
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 7, 1, 7, 0, 1, 1);
         tick();
      end
      drive(1, 7, 1, 7, 0, 1, 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (got_taken[m] !== 1'b0 || got_ghr[m] !== 6'd0 || got_br[m] !== 32'd0 || got_mp[m] !== 32'd0)
            $display("FAIL async_reset_now[%0d]: got t=%0d g=%0d b=%0d m=%0d want all 0",
                     m, got_taken[m], got_ghr[m], got_br[m], got_mp[m]);
         else passed++;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 7, 0, 0, 0, 0, 0);
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (got_taken[m] !== 1'b0 || got_br[m] !== 32'd0 || got_ghr[m] !== 6'd0)
            $display("FAIL async_reset_after[%0d]: got t=%0d g=%0d b=%0d want 0/0/0",
                     m, got_taken[m], got_ghr[m], got_br[m]);
         else passed++;
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_saturation();
      test_aliasing();
      test_repair();
      test_stats();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised direction predictor for the ID stage, successor to the 2-bit bimodal table. It keeps a table of N-bit saturating counters indexed by PC bits, XORed with a speculative global history register (GHR) in gshare mode. It repairs the history on mispredict and keeps branch and mispredict statistics. Prediction is served combinationally to fetch/decode; training arrives from branch resolution, possibly several cycles later.

## Interface
- INDEX_WIDTH, 6: table index width; the table has 2^INDEX_WIDTH entries.
- HISTORY_WIDTH, 6: GHR width; legal range 1..INDEX_WIDTH.
- COUNTER_WIDTH, 2: saturating counter width, 2..4.
- GSHARE_EN, 1: 1 = index is PC XOR GHR; 0 = bimodal (PC only, GHR still maintained).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pred_valid  in  1  a branch is being predicted this cycle.
- pred_pc_slice  in  INDEX_WIDTH  PC[INDEX_WIDTH+1:2] of the predicted branch.
- pred_taken  out  1  predicted direction.
- pred_ghr  out  HISTORY_WIDTH  GHR snapshot used for this prediction; the pipeline carries it to resolution.
- upd_valid  in  1  a resolved branch trains the table this cycle.
- upd_pc_slice  in  INDEX_WIDTH  PC slice of the resolved branch.
- upd_ghr  in  HISTORY_WIDTH  snapshot returned from pred_ghr.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  outcome differed from the prediction; qualified by upd_valid.
- stat_branches  out  32  count of upd_valid cycles.
- stat_mispredicts  out  32  count of upd_valid && upd_mispredict cycles.

## Operation
- Index function: idx = slice XOR {zeros, ghr}, with the GHR aligned to the LSBs. Bimodal mode uses idx = slice.
- Prediction: pred_taken = MSB of counter[idx(pred_pc_slice, GHR)]; pred_ghr = GHR. Both are pure combinational and independent of pred_valid.
- Speculative history: when pred_valid is high, GHR <= {GHR[H-2:0], pred_taken} at the clock edge. With H=1, GHR <= pred_taken.
- Training: when upd_valid is high, the counter at idx(upd_pc_slice, upd_ghr) changes as follows:
  - taken: increments, saturating at 2^C-1.
  - not taken: decrements, saturating at 0.
- Repair: when upd_valid && upd_mispredict, GHR <= {upd_ghr[H-2:0], upd_taken}. Repair overrides a simultaneous pred_valid shift.
- Statistics:
  - stat_branches increments by 1 per upd_valid cycle.
  - stat_mispredicts increments by 1 per upd_valid && upd_mispredict cycle.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
- upd_mispredict without upd_valid is ignored entirely.
- Simultaneous predict and train on the same index: prediction returns the pre-update counter, with no bypass.
- Reset (async, any time including mid-stream):
  - every counter = 2^(C-1)-1 (weakly not taken; 01 for C=2).
  - GHR = 0.
  - stats = 0.
  - Consequently pred_taken = 0 and pred_ghr = 0 during and immediately after reset.

## Timing
- Prediction latency 0 cycles; combinational from pred_pc_slice and the current state.
- Training becomes visible to pred_taken on the cycle after the upd_valid edge.
- GHR shift or repair becomes visible on pred_ghr one cycle after the edge.
- Statistics update one cycle after the qualifying edge.
- No handshake or backpressure: every valid input is consumed in the cycle it is presented.

## Test plan
- Reset state:
  - Stimulus: assert rst; release; pred_pc_slice=5.
  - Required: pred_taken=0, pred_ghr=0, both stats 0.
  - Sweep all 64 slices: each predicts not taken.
- Saturation:
  - Stimulus: upd_valid with pc=5, ghr=0, taken for 5 cycles.
  - Required: pred_taken (pc=5, GHR=0) =1 after the 1st update; counter stays 11.
  - Then 1 not-taken: still taken (10). After 2 more not-taken: pred_taken=0 (00).
- Gshare aliasing:
  - Stimulus: train index 0 to 11; then drive pred_valid with taken outcomes so GHR=6'b000101.
  - Required: pc=5 predicts taken (5^5=0).
  - Same sequence with GSHARE_EN=0: pc=5 predicts 0.
- Speculation and repair:
  - Stimulus: 3 pred_valid cycles predicting taken (GHR -> 000111); then upd_valid+upd_mispredict, upd_ghr=000001, upd_taken=0, in the same cycle as pred_valid.
  - Required: next pred_ghr=000010, and the speculative shift is discarded.
- Statistics:
  - Stimulus: 10 updates, 3 with mispredict; plus one cycle with upd_mispredict=1 and upd_valid=0.
  - Required: stat_branches=10, stat_mispredicts=3.
  - Force counters near all-ones: values hold at FFFF_FFFF.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while upd_valid is high.
  - Required: outputs go to reset values immediately, with no update applied.
